// File: rtl/spi_wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_wave_pkg
// Description : Shared constants and SPI mode helper for the wave SPI receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_wave_pkg;

    localparam int c_SYNC_STAGES = 3;
    localparam int c_DATA_W_MIN  = 2;
    localparam int c_DATA_W_MAX  = 32;

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_wave_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_wave_rx_if
// Description : SPI pin and receive-FIFO handshake bundle for spi_wave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_wave_rx_if #(
    parameter int DATA_W = 16
);
    logic              enable;
    logic              SCK;
    logic              SSEL;
    logic              MOSI;
    logic              MISO;
    logic              MISO_OE;
    logic [DATA_W-1:0] TX_WORD;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_VALID;
    logic              DATA_POP;
    logic              DATA_READY;
    logic              OVERFLOW;
    logic              FRAME_ERR;

    modport slave (
        input  enable, SCK, SSEL, MOSI, TX_WORD, DATA_POP,
        output MISO, MISO_OE, DATA_OUT, DATA_VALID, DATA_READY, OVERFLOW, FRAME_ERR
    );

    modport master (
        output enable, SCK, SSEL, MOSI, TX_WORD, DATA_POP,
        input  MISO, MISO_OE, DATA_OUT, DATA_VALID, DATA_READY, OVERFLOW, FRAME_ERR
    );
endinterface
`default_nettype wire

// File: rtl/spi_wave_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_wave_fifo
// Description : Synchronous FIFO for received SPI words; pop precedes push.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_wave_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_wave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_wave_rx
// Description : Oversampling SPI slave with receive FIFO and MISO word shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_wave_rx
    import spi_wave_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_wave_rx_if.slave bus
);
    localparam int                 c_CNT_W       = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST        = c_CNT_W'(DATA_W - 1);
    localparam int                 c_HI          = c_SYNC_STAGES - 1;
    localparam bit                 c_SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    generate
        if (DATA_W < c_DATA_W_MIN || DATA_W > c_DATA_W_MAX) begin : g_bad_width
            $error("spi_wave_rx: DATA_W out of range");
        end
    endgenerate

    logic [c_SYNC_STAGES-1:0] r_sck_s;
    logic [c_SYNC_STAGES-1:0] r_ssel_s;
    logic [c_SYNC_STAGES-1:0] r_mosi_s;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]        r_rx_sh;
    logic [DATA_W-1:0]        r_tx_sh;
    logic                     r_tx_armed;
    logic                     r_miso;
    logic                     r_push;
    logic                     r_overflow;
    logic                     r_frame_err;

    logic                     w_sck_rise;
    logic                     w_sck_fall;
    logic                     w_sample;
    logic                     w_shift;
    logic                     w_active;
    logic                     w_last;
    logic                     w_mosi;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_W-1:0]        w_fifo_rdata;
    logic [DATA_W-1:0]        w_rx_next;
    logic                     w_load_bit;
    logic [DATA_W-1:0]        w_load_rest;
    logic                     w_tx_bit;
    logic [DATA_W-1:0]        w_tx_rest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_s  <= {c_SYNC_STAGES{CPOL}};
            r_ssel_s <= '1;
            r_mosi_s <= '0;
        end else begin
            r_sck_s  <= {r_sck_s[c_HI-1:0], bus.SCK};
            r_ssel_s <= {r_ssel_s[c_HI-1:0], bus.SSEL};
            r_mosi_s <= {r_mosi_s[c_HI-1:0], bus.MOSI};
        end
    end

    assign w_sck_rise = (r_sck_s[c_HI -: 2] == 2'b01);
    assign w_sck_fall = (r_sck_s[c_HI -: 2] == 2'b10);
    assign w_sample   = c_SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift    = c_SAMPLE_RISE ? w_sck_fall : w_sck_rise;
    assign w_active   = ~r_ssel_s[c_HI] & bus.enable;
    assign w_mosi     = r_mosi_s[c_HI];
    assign w_last     = (r_bit_cnt == c_LAST);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_rx_next   = {r_rx_sh[DATA_W-2:0], w_mosi};
            assign w_load_bit  = bus.TX_WORD[DATA_W-1];
            assign w_load_rest = {bus.TX_WORD[DATA_W-2:0], 1'b0};
            assign w_tx_bit    = r_tx_sh[DATA_W-1];
            assign w_tx_rest   = {r_tx_sh[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_rx_next   = {w_mosi, r_rx_sh[DATA_W-1:1]};
            assign w_load_bit  = bus.TX_WORD[0];
            assign w_load_rest = {1'b0, bus.TX_WORD[DATA_W-1:1]};
            assign w_tx_bit    = r_tx_sh[0];
            assign w_tx_rest   = {1'b0, r_tx_sh[DATA_W-1:1]};
        end
    endgenerate

    // Receive path: leaving the active state mid-word is a framing error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (!w_active) begin
                r_bit_cnt <= '0;
                r_rx_sh   <= '0;
                if (r_bit_cnt != '0) begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_sample) begin
                r_rx_sh <= w_rx_next;
                if (w_last) begin
                    r_bit_cnt <= '0;
                    r_push    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // CPHA=0 presents the first bit at load and skips the trailing edge after a wrap;
    // CPHA=1 emits every bit on a leading edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_sh    <= '0;
            r_tx_armed <= 1'b0;
            r_miso     <= 1'b0;
        end else if (!w_active) begin
            r_tx_sh    <= '0;
            r_tx_armed <= 1'b0;
            r_miso     <= 1'b0;
        end else if (!r_tx_armed) begin
            r_tx_armed <= 1'b1;
            if (CPHA) begin
                r_tx_sh <= bus.TX_WORD;
            end else begin
                r_tx_sh <= w_load_rest;
                r_miso  <= w_load_bit;
            end
        end else begin
            if (w_sample && w_last) begin
                r_tx_armed <= 1'b0;
            end
            if (w_shift && (CPHA || (r_bit_cnt != '0))) begin
                r_miso  <= w_tx_bit;
                r_tx_sh <= w_tx_rest;
            end
        end
    end

    assign w_pop = bus.DATA_POP & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    spi_wave_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_wdata (r_rx_sh),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.MISO       = w_active & r_miso;
    assign bus.MISO_OE    = w_active;
    assign bus.DATA_OUT   = w_fifo_rdata;
    assign bus.DATA_VALID = ~w_empty;
    assign bus.DATA_READY = r_push;
    assign bus.OVERFLOW   = r_overflow;
    assign bus.FRAME_ERR  = r_frame_err;

endmodule
`default_nettype wire
